bird_layer: RTL and testbench
=============================

# bird_layer

Game-state and pixel layer for the flapping bird. Sits between the pixel iterator and the RGB output mux. It consumes the iterator's x/y/de stream plus a flap button, runs per-frame bird physics (gravity, flap impulse, ceiling/floor death), and emits a registered bird-colour pixel with a matching delayed de. The output mux selects these pixels the same way it selects the test pattern.

## Interface
- HOR_ACTIVE_PIXELS, 640, active pixels per line
- VER_ACTIVE_PIXELS, 480, active lines per frame
- BIRD_X, 160, left column of the bird square
- BIRD_SIZE, 16, bird square edge in pixels
- GRAVITY, 1, velocity increment per frame (pixels/frame²)
- FLAP_VELOCITY, -8, signed velocity loaded on flap
- MAX_FALL_VELOCITY, 8, positive velocity clamp
- X_WIDTH / Y_WIDTH, $clog2 of active sizes (10 / 9)
- clk_rgb  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  clock enable; when low every register holds
- x  in  X_WIDTH  current pixel column
- y  in  Y_WIDTH  current pixel row
- de  in  1  active-video flag for x/y
- flap  in  1  raw button level, active-high, asynchronous to clk_rgb
- de_out  out  1  de delayed one ce-cycle, aligned with r/g/b/hit
- hit  out  1  registered: current pixel is bird
- r, g, b  out  8 each  registered bird colour; 0 when hit=0
- bird_y  out  Y_WIDTH  top row of the bird
- dead  out  1  high while in DEAD

## Operation
- flap passes through a 2-flop synchronizer; rising edge of the synchronized level = flap_rise. flap_rise sets flap_pending.
- frame_tick = ce & de & (x == HOR_ACTIVE_PIXELS-1) & (y == VER_ACTIVE_PIXELS-1), i.e. the last active pixel. At frame_tick, req = flap_pending | flap_rise. flap_pending clears on every frame_tick, whether req is used or not.
- States (2-bit): IDLE, FLYING, DEAD.
- Reset values: state IDLE; bird_y = (VER_ACTIVE_PIXELS-BIRD_SIZE)/2 = 232; vel = 0; flap_pending 0; synchronizer 0; hit, de_out, r, g, b, dead all 0.
- IDLE: bird_y and vel held. On frame_tick with req, go to FLYING and apply the flap update in that same tick.
- FLYING, on frame_tick:
  - vel_n = req ? FLAP_VELOCITY : min(vel+GRAVITY, MAX_FALL_VELOCITY).
  - pos_n = bird_y + vel_n, computed signed in Y_WIDTH+2 bits.
  - If pos_n < 0: bird_y = 0, vel = 0, go to DEAD.
  - Else if pos_n > VER_ACTIVE_PIXELS-BIRD_SIZE (464): bird_y = 464, vel = 0, go to DEAD.
  - pos_n == 0 or pos_n == 464 is alive.
- DEAD: position frozen. On frame_tick with req, go to IDLE with bird_y = 232 and vel = 0.
- vel is 8-bit signed.
- Pixel, registered when ce:
  - hit = de & (BIRD_X ≤ x < BIRD_X+BIRD_SIZE) & (bird_y ≤ y < bird_y+BIRD_SIZE).
  - Colour when hit and not DEAD: 255/220/0 (yellow).
  - Colour when hit and DEAD: 255/0/0 (red).
  - Otherwise 0/0/0.
  - dead is a direct decode of state.
- Compares use the bird_y value before the frame_tick update. The update lands after the last active pixel, so a frame never tears.

## Timing
- r/g/b/hit/de_out lag x/y/de by exactly 1 ce-cycle. The integrator delays hs/vs by one cycle to match.
- State/physics registers update on the clk_rgb edge following frame_tick.
- Flap latency: the synchronizer takes 2 cycles, then the request waits up to one frame for frame_tick.
- A flap edge on the frame_tick cycle itself is consumed by that tick.
- Multiple edges within one frame collapse into one request.
- rst mid-frame or mid-flight returns to the reset values on the next edge, with priority over ce.

## Test plan
- Reset: assert rst 2 cycles -> bird_y=232, dead=0, hit=0, r=g=b=0, de_out=0.
- Start: flap pulse in IDLE, then one frame_tick -> FLYING, bird_y=224, vel=-8. After 8 further ticks with no flap -> bird_y=196, vel=0.
- Floor: continue with no flaps -> bird_y reaches 464 with dead=0. The next tick -> bird_y=464, dead=1.
- Ceiling: one flap edge per frame from start -> bird_y=0 after 29 ticks with dead=0. The 30th flap -> dead=1, bird_y=0.
- Pixel/latency: bird_y=232, drive de=1, x=160, y=232 -> one cycle later hit=1, rgb=255/220/0, de_out=1. x=176 -> hit=0, rgb=0. When dead: rgb=255/0/0.
- ce/restart: ce=0 across a frame_tick -> no state change. In DEAD, flap + tick -> IDLE, bird_y=232, dead=0. Flap edge on the tick cycle -> consumed the same tick.

Source files
------------

// File: rtl/bird_layer_if.sv
// Pixel stream between the iterator and the bird layer, plus the registered
// bird pixel returned toward the RGB mux.
//   x, y, de          : iterator pixel coordinates and active-video flag
//   de_out, hit, r/g/b: bird pixel, one ce-cycle behind x/y/de
interface bird_layer_if #(
  parameter int unsigned X_WIDTH = 10,
  parameter int unsigned Y_WIDTH = 9
);
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;
  logic               de;
  logic               de_out;
  logic               hit;
  logic [7:0]         r;
  logic [7:0]         g;
  logic [7:0]         b;

  modport master (output x, y, de, input de_out, hit, r, g, b);
  modport slave  (input x, y, de, output de_out, hit, r, g, b);
endinterface

// File: rtl/bird_layer.sv
// Flapping-bird game state and pixel layer.
// Runs per-frame bird physics (gravity, flap impulse, ceiling/floor death)
// and emits a registered bird-colour pixel with a matching delayed de.
//   clk_rgb : pixel clock
//   rst     : synchronous active-high reset, priority over ce
//   ce      : clock enable, every register holds while low
//   flap    : raw asynchronous button level, active-high
//   pix     : iterator x/y/de in, bird pixel de_out/hit/r/g/b out
//   bird_y  : top row of the bird square
//   dead    : high while in DEAD
module bird_layer #(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480,
  parameter int unsigned BIRD_X            = 160,
  parameter int unsigned BIRD_SIZE         = 16,
  parameter int          GRAVITY           = 1,
  parameter int          FLAP_VELOCITY     = -8,
  parameter int          MAX_FALL_VELOCITY = 8
) (
  input  logic                                        clk_rgb,
  input  logic                                        rst,
  input  logic                                        ce,
  input  logic                                        flap,
  bird_layer_if.slave                                 pix,
  output logic [$clog2(VER_ACTIVE_PIXELS)-1:0]        bird_y,
  output logic                                        dead
);
  localparam int unsigned X_WIDTH = $clog2(HOR_ACTIVE_PIXELS);
  localparam int unsigned Y_WIDTH = $clog2(VER_ACTIVE_PIXELS);
  localparam int unsigned PW      = Y_WIDTH + 2;
  localparam int unsigned YE      = Y_WIDTH + 1;
  localparam int unsigned Y_MAX   = VER_ACTIVE_PIXELS - BIRD_SIZE;

  localparam logic [Y_WIDTH-1:0]   Y_INIT     = Y_WIDTH'(Y_MAX / 2);
  localparam logic [Y_WIDTH-1:0]   Y_FLOOR    = Y_WIDTH'(Y_MAX);
  localparam logic signed [PW-1:0] POS_MAX    = PW'(Y_MAX);
  localparam logic signed [7:0]    VEL_FLAP   = 8'(FLAP_VELOCITY);
  localparam logic signed [7:0]    VEL_GRAV   = 8'(GRAVITY);
  localparam logic signed [7:0]    VEL_MAX    = 8'(MAX_FALL_VELOCITY);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLYING = 2'd1,
    DEAD   = 2'd2
  } state_t;

  state_t              state;
  logic signed [7:0]   vel;
  logic                flap_meta;
  logic                flap_sync;
  logic                flap_prev;
  logic                flap_pending;

  logic                flap_rise_c;
  logic                frame_tick_c;
  logic                req_c;
  logic                hit_c;
  logic signed [7:0]   vel_inc_c;
  logic signed [7:0]   fly_vel_c;
  logic signed [PW-1:0] fly_pos_c;
  logic                under_c;
  logic                over_c;

  // Control strobes: synchronized flap edge and last-active-pixel tick.
  always_comb begin
    flap_rise_c  = flap_sync & ~flap_prev;
    frame_tick_c = ce & pix.de & (pix.x == X_WIDTH'(HOR_ACTIVE_PIXELS - 1))
                   & (pix.y == Y_WIDTH'(VER_ACTIVE_PIXELS - 1));
    req_c        = flap_pending | flap_rise_c;
  end

  // Candidate physics update for one frame of flight.
  always_comb begin
    vel_inc_c = vel + VEL_GRAV;
    if (req_c)
      fly_vel_c = VEL_FLAP;
    else if (vel_inc_c > VEL_MAX)
      fly_vel_c = VEL_MAX;
    else
      fly_vel_c = vel_inc_c;
    fly_pos_c = $signed({2'b00, bird_y}) + PW'(fly_vel_c);
    under_c   = fly_pos_c[PW-1];
    over_c    = fly_pos_c > POS_MAX;
  end

  // Bird square test against the pre-update bird_y.
  always_comb begin
    hit_c = pix.de
            && (pix.x >= X_WIDTH'(BIRD_X))
            && (pix.x <  X_WIDTH'(BIRD_X + BIRD_SIZE))
            && ({1'b0, pix.y} >= {1'b0, bird_y})
            && ({1'b0, pix.y} <  ({1'b0, bird_y} + YE'(BIRD_SIZE)));
  end

  // Game FSM, flap synchronizer and registered pixel output.
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      state        <= IDLE;
      bird_y       <= Y_INIT;
      vel          <= '0;
      flap_meta    <= 1'b0;
      flap_sync    <= 1'b0;
      flap_prev    <= 1'b0;
      flap_pending <= 1'b0;
      dead         <= 1'b0;
      pix.de_out   <= 1'b0;
      pix.hit      <= 1'b0;
      pix.r        <= '0;
      pix.g        <= '0;
      pix.b        <= '0;
    end else if (ce) begin
      flap_meta <= flap;
      flap_sync <= flap_meta;
      flap_prev <= flap_sync;

      // A tick always consumes any pending request, used or not.
      if (frame_tick_c)
        flap_pending <= 1'b0;
      else if (flap_rise_c)
        flap_pending <= 1'b1;

      pix.de_out <= pix.de;
      pix.hit    <= hit_c;
      pix.r      <= hit_c ? 8'd255 : 8'd0;
      pix.g      <= (hit_c && state != DEAD) ? 8'd220 : 8'd0;
      pix.b      <= '0;

      if (frame_tick_c) begin
        case (state)
          IDLE, FLYING: begin
            // IDLE waits for a request, then flaps in the same tick.
            if (state == FLYING || req_c) begin
              if (under_c) begin
                bird_y <= '0;
                vel    <= '0;
                state  <= DEAD;
                dead   <= 1'b1;
              end else if (over_c) begin
                bird_y <= Y_FLOOR;
                vel    <= '0;
                state  <= DEAD;
                dead   <= 1'b1;
              end else begin
                bird_y <= Y_WIDTH'(fly_pos_c);
                vel    <= fly_vel_c;
                state  <= FLYING;
              end
            end
          end
          DEAD: begin
            if (req_c) begin
              bird_y <= Y_INIT;
              vel    <= '0;
              state  <= IDLE;
              dead   <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            dead  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bird_layer.sv
// Directed bench for bird_layer: table-driven pixel vectors plus
// hand-written multi-cycle sequences for physics, death, ce and restart.
module tb_bird_layer;
  logic       clk_rgb;
  logic       rst;
  logic       ce;
  logic       flap;
  logic [8:0] bird_y;
  logic       dead;

  int tests_run;
  int tests_failed;

  bird_layer_if #(.X_WIDTH(10), .Y_WIDTH(9)) pix_if ();

  bird_layer dut (
    .clk_rgb (clk_rgb),
    .rst     (rst),
    .ce      (ce),
    .flap    (flap),
    .pix     (pix_if.slave),
    .bird_y  (bird_y),
    .dead    (dead)
  );

  initial clk_rgb = 1'b0;
  always #5 clk_rgb = ~clk_rgb;

  typedef struct {
    logic       de;
    int         x;
    int         y;
    int         exp_hit;
    int         exp_r;
    int         exp_g;
    int         exp_b;
    int         exp_de_out;
  } vec_t;

  vec_t alive_vecs[8];
  vec_t dead_vecs[4];

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one pixel at a falling edge and check the result one cycle later.
  task automatic apply_vec(input string tag, input int idx, input vec_t v);
    pix_if.de = v.de;
    pix_if.x  = 10'(v.x);
    pix_if.y  = 9'(v.y);
    @(negedge clk_rgb);
    check($sformatf("%s[%0d].hit", tag, idx), int'(pix_if.hit), v.exp_hit);
    check($sformatf("%s[%0d].r", tag, idx), int'(pix_if.r), v.exp_r);
    check($sformatf("%s[%0d].g", tag, idx), int'(pix_if.g), v.exp_g);
    check($sformatf("%s[%0d].b", tag, idx), int'(pix_if.b), v.exp_b);
    check($sformatf("%s[%0d].de_out", tag, idx), int'(pix_if.de_out), v.exp_de_out);
    pix_if.de = 1'b0;
  endtask

  // One cycle on the last active pixel of the frame.
  task automatic tick();
    pix_if.de = 1'b1;
    pix_if.x  = 10'd639;
    pix_if.y  = 9'd479;
    @(negedge clk_rgb);
    pix_if.de = 1'b0;
    pix_if.x  = 10'd0;
    pix_if.y  = 9'd0;
  endtask

  // Button press long enough to clear the synchronizer, then release.
  task automatic do_flap();
    flap = 1'b1;
    repeat (3) @(negedge clk_rgb);
    flap = 1'b0;
    repeat (3) @(negedge clk_rgb);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk_rgb);
    rst = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //                 de  x    y    hit r    g    b  de_out
    alive_vecs[0] = '{1'b1, 160, 232, 1, 255, 220, 0, 1};
    alive_vecs[1] = '{1'b1, 175, 247, 1, 255, 220, 0, 1};
    alive_vecs[2] = '{1'b1, 176, 232, 0, 0,   0,   0, 1};
    alive_vecs[3] = '{1'b1, 159, 232, 0, 0,   0,   0, 1};
    alive_vecs[4] = '{1'b1, 160, 248, 0, 0,   0,   0, 1};
    alive_vecs[5] = '{1'b1, 160, 231, 0, 0,   0,   0, 1};
    alive_vecs[6] = '{1'b0, 160, 232, 0, 0,   0,   0, 0};
    alive_vecs[7] = '{1'b1, 0,   0,   0, 0,   0,   0, 1};

    dead_vecs[0]  = '{1'b1, 160, 464, 1, 255, 0,   0, 1};
    dead_vecs[1]  = '{1'b1, 175, 479, 1, 255, 0,   0, 1};
    dead_vecs[2]  = '{1'b1, 160, 463, 0, 0,   0,   0, 1};
    dead_vecs[3]  = '{1'b1, 176, 470, 0, 0,   0,   0, 1};

    rst       = 1'b1;
    ce        = 1'b1;
    flap      = 1'b0;
    pix_if.de = 1'b0;
    pix_if.x  = '0;
    pix_if.y  = '0;
    repeat (2) @(negedge clk_rgb);
    check("reset.bird_y", int'(bird_y), 232);
    check("reset.dead", int'(dead), 0);
    check("reset.hit", int'(pix_if.hit), 0);
    check("reset.rgb", int'({pix_if.r, pix_if.g, pix_if.b}), 0);
    check("reset.de_out", int'(pix_if.de_out), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) apply_vec("alive", i, alive_vecs[i]);

    // Idle tick without a request leaves the bird alone.
    tick();
    check("idle_tick.bird_y", int'(bird_y), 232);

    // Start, rise to apex, fall to the floor.
    do_flap();
    tick();
    check("start.bird_y", int'(bird_y), 224);
    check("start.dead", int'(dead), 0);
    repeat (8) tick();
    check("apex.bird_y", int'(bird_y), 196);
    repeat (8) tick();
    check("fall8.bird_y", int'(bird_y), 232);
    repeat (29) tick();
    check("floor.bird_y", int'(bird_y), 464);
    check("floor.dead", int'(dead), 0);
    tick();
    check("floor_die.bird_y", int'(bird_y), 464);
    check("floor_die.dead", int'(dead), 1);

    for (int i = 0; i < 4; i++) apply_vec("dead", i, dead_vecs[i]);

    // ce low across a tick freezes everything, then restart on the next tick.
    do_flap();
    ce = 1'b0;
    tick();
    ce = 1'b1;
    check("ce_off.bird_y", int'(bird_y), 464);
    check("ce_off.dead", int'(dead), 1);
    tick();
    check("restart.bird_y", int'(bird_y), 232);
    check("restart.dead", int'(dead), 0);
    tick();
    check("restart_idle.bird_y", int'(bird_y), 232);

    // Flap edge arriving on the tick cycle is consumed by that tick.
    flap = 1'b1;
    repeat (2) @(negedge clk_rgb);
    tick();
    flap = 1'b0;
    check("edge_on_tick.bird_y", int'(bird_y), 224);
    tick();
    check("edge_consumed.bird_y", int'(bird_y), 217);

    // Reset mid-flight.
    do_reset();
    check("midreset.bird_y", int'(bird_y), 232);
    check("midreset.dead", int'(dead), 0);

    // Two presses in one frame collapse into one request.
    do_flap();
    do_flap();
    tick();
    check("collapse1.bird_y", int'(bird_y), 224);
    tick();
    check("collapse2.bird_y", int'(bird_y), 217);

    // Ceiling: one flap per frame.
    do_reset();
    for (int k = 0; k < 29; k++) begin
      do_flap();
      tick();
    end
    check("ceiling.bird_y", int'(bird_y), 0);
    check("ceiling.dead", int'(dead), 0);
    do_flap();
    tick();
    check("ceiling_die.bird_y", int'(bird_y), 0);
    check("ceiling_die.dead", int'(dead), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
